blur_sequencer: RTL and testbench

Controller for the Gaussian blur datapath. It owns the kernel builder (`CreateKernel`) and the convolution engine (`ComputeKernel`), and drives both from one clock. It accepts a blur configuration, triggers a kernel rebuild whenever the configuration changes, then admits one pixel window at a time. Each window is registered and held stable for the convolution; each result is returned through a valid/ready output register. It sits between the window/line-buffer front end and the pixel writeback stage.

---
 rtl/blur_pkg.sv | 23 ++
 rtl/blur_sequencer_if.sv | 22 ++
 rtl/blur_watchdog.sv | 28 ++
 rtl/blur_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_blur_sequencer.sv | 468 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/blur_pkg.sv
// Shared types and constants for the blur sequencer.
// State encoding, error codes and the window matrix type.
package blur_pkg;

    localparam int MAX_KERNEL = 7;

    typedef enum logic [2:0] {
        ST_NO_KERNEL,
        ST_BUILD,
        ST_READY,
        ST_COMPUTE,
        ST_OUTPUT,
        ST_ERROR
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_BUILD   = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_SIZE    = 2'd3;

    typedef logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][7:0] win_t;

endpackage

// File: rtl/blur_sequencer_if.sv
// Window and pixel handshakes of the blur sequencer.
// master: front end / writeback side, slave: the sequencer.
interface blur_sequencer_if #(
    parameter int N = 7
);
    logic                       win_valid;
    logic                       win_ready;
    logic [N-1:0][N-1:0][7:0]   win_matrix;
    logic                       pix_valid;
    logic                       pix_ready;
    logic [7:0]                 pix_data;

    modport master (
        output win_valid, win_matrix, pix_ready,
        input  win_ready, pix_valid, pix_data
    );

    modport slave (
        input  win_valid, win_matrix, pix_ready,
        output win_ready, pix_valid, pix_data
    );
endinterface

// File: rtl/blur_watchdog.sv
// Timeout counter: cleared on wait entry, counts while enabled,
// and flags expiry on the last allowed cycle of the wait.
module blur_watchdog #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    assign expire = enable && (count == CW'(LIMIT - 1));

    // Count cycles spent waiting; clear wins over enable.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expire) begin
            count <= count + CW'(1);
        end
    end
endmodule

// File: rtl/blur_sequencer.sv
// Gaussian blur controller: sequences kernel builds and
// one-window-at-a-time convolutions with a watchdog.
module blur_sequencer #(
    parameter int MAX_KERNEL     = 7,
    parameter int KW             = $clog2(MAX_KERNEL),
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic                      cfg_valid,
    input  logic [2:0]                cfg_sigma,
    input  logic [KW-1:0]             cfg_kernel_size,
    blur_sequencer_if.slave           bus,
    output logic                      kb_start,
    input  logic                      kb_done,
    input  logic                      kb_err,
    output logic [2:0]                kb_sigma,
    output logic [KW-1:0]             kb_kernel_size,
    output logic                      ck_start,
    input  logic                      ck_done,
    input  logic [7:0]                ck_pixel,
    output logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][7:0] ck_matrix,
    output logic [KW-1:0]             ck_kernel_size,
    output logic                      ck_clear,
    output logic                      busy,
    output logic [1:0]                err_code,
    output logic [15:0]               pix_count
);
    import blur_pkg::*;

    typedef logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][7:0] mat_t;

    state_t        state_q, state_d;
    logic [2:0]    sig_q, sig_d, psig_q, psig_d;
    logic [KW-1:0] size_q, size_d, psize_q, psize_d;
    logic          pend_q, pend_d;
    logic          kb_start_q, kb_start_d;
    logic          ck_clear_q, ck_clear_d;
    logic          ck_start_q, ck_start_d;
    logic          pix_valid_q, pix_valid_d;
    logic [7:0]    pix_data_q, pix_data_d;
    mat_t          mat_q, mat_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [1:0]    err_q, err_d;

    logic          load;
    logic [2:0]    ld_sig;
    logic [KW-1:0] ld_size;
    logic          eff_pend;
    logic [2:0]    eff_sig;
    logic [KW-1:0] eff_size;
    logic          wd_clear, wd_en, wd_expire;

    function automatic logic size_ok(input logic [KW-1:0] s);
        return s[0] && (s >= KW'(3)) && (int'(s) <= MAX_KERNEL);
    endfunction

    assign wd_en = (state_q == ST_BUILD) || (state_q == ST_COMPUTE);

    blur_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wd (
        .clk    (clk),
        .n_rst  (n_rst),
        .clear  (wd_clear),
        .enable (wd_en),
        .expire (wd_expire)
    );

    assign bus.win_ready  = (state_q == ST_READY);
    assign bus.pix_valid  = pix_valid_q;
    assign bus.pix_data   = pix_data_q;
    assign busy           = !((state_q == ST_READY) ||
                              (state_q == ST_NO_KERNEL));
    assign kb_start       = kb_start_q;
    assign kb_sigma       = sig_q;
    assign kb_kernel_size = size_q;
    assign ck_start       = ck_start_q;
    assign ck_clear       = ck_clear_q;
    assign ck_matrix      = mat_q;
    assign ck_kernel_size = size_q;
    assign err_code       = err_q;
    assign pix_count      = cnt_q;

    // Next state and next register values; a config load is
    // resolved last so every state shares the same rebuild path.
    always_comb begin
        state_d     = state_q;
        sig_d       = sig_q;
        size_d      = size_q;
        psig_d      = psig_q;
        psize_d     = psize_q;
        pend_d      = pend_q;
        kb_start_d  = 1'b0;
        ck_clear_d  = 1'b0;
        ck_start_d  = 1'b0;
        pix_valid_d = pix_valid_q;
        pix_data_d  = pix_data_q;
        mat_d       = mat_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        wd_clear    = 1'b0;
        load        = 1'b0;
        ld_sig      = cfg_sigma;
        ld_size     = cfg_kernel_size;
        eff_pend    = pend_q || cfg_valid;
        eff_sig     = cfg_valid ? cfg_sigma : psig_q;
        eff_size    = cfg_valid ? cfg_kernel_size : psize_q;

        if (cfg_valid) begin
            pend_d  = 1'b1;
            psig_d  = cfg_sigma;
            psize_d = cfg_kernel_size;
        end

        unique case (state_q)
            ST_NO_KERNEL, ST_ERROR: begin
                if (cfg_valid) load = 1'b1;
            end
            ST_READY: begin
                if (cfg_valid) begin
                    load = 1'b1;
                end else if (bus.win_valid) begin
                    mat_d      = bus.win_matrix;
                    ck_start_d = 1'b1;
                    wd_clear   = 1'b1;
                    state_d    = ST_COMPUTE;
                end
            end
            ST_BUILD: begin
                if (kb_done) begin
                    if (kb_err) begin
                        state_d = ST_ERROR;
                        err_d   = ERR_BUILD;
                        pend_d  = 1'b0;
                    end else if (eff_pend) begin
                        load    = 1'b1;
                        ld_sig  = eff_sig;
                        ld_size = eff_size;
                    end else begin
                        state_d = ST_READY;
                    end
                end else if (wd_expire) begin
                    state_d = ST_ERROR;
                    err_d   = ERR_TIMEOUT;
                    pend_d  = 1'b0;
                end
            end
            ST_COMPUTE: begin
                if (ck_done) begin
                    pix_data_d  = ck_pixel;
                    pix_valid_d = 1'b1;
                    cnt_d       = cnt_q + 16'd1;
                    state_d     = ST_OUTPUT;
                end else if (wd_expire) begin
                    state_d = ST_ERROR;
                    err_d   = ERR_TIMEOUT;
                    pend_d  = 1'b0;
                end
            end
            ST_OUTPUT: begin
                if (bus.pix_ready) begin
                    pix_valid_d = 1'b0;
                    if (eff_pend) begin
                        load    = 1'b1;
                        ld_sig  = eff_sig;
                        ld_size = eff_size;
                    end else begin
                        state_d = ST_READY;
                    end
                end
            end
            default: state_d = ST_NO_KERNEL;
        endcase

        if (load) begin
            pend_d = 1'b0;
            sig_d  = ld_sig;
            size_d = ld_size;
            if (!size_ok(ld_size)) begin
                state_d = ST_ERROR;
                err_d   = ERR_SIZE;
            end else begin
                state_d    = ST_BUILD;
                kb_start_d = 1'b1;
                ck_clear_d = 1'b1;
                cnt_d      = '0;
                err_d      = ERR_NONE;
                wd_clear   = 1'b1;
            end
        end
    end

    // State and datapath registers; reset drops any pending config.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= ST_NO_KERNEL;
            sig_q       <= 3'd1;
            size_q      <= KW'(3);
            psig_q      <= '0;
            psize_q     <= '0;
            pend_q      <= 1'b0;
            kb_start_q  <= 1'b0;
            ck_clear_q  <= 1'b0;
            ck_start_q  <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_data_q  <= '0;
            mat_q       <= '0;
            cnt_q       <= '0;
            err_q       <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            sig_q       <= sig_d;
            size_q      <= size_d;
            psig_q      <= psig_d;
            psize_q     <= psize_d;
            pend_q      <= pend_d;
            kb_start_q  <= kb_start_d;
            ck_clear_q  <= ck_clear_d;
            ck_start_q  <= ck_start_d;
            pix_valid_q <= pix_valid_d;
            pix_data_q  <= pix_data_d;
            mat_q       <= mat_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
        end
    end
endmodule

// File: tb/tb_blur_sequencer.sv
// Bench for blur_sequencer with stub kernel builder and engine.
// Expected values come from a small model of configs and counts.
module tb_blur_sequencer;
    import blur_pkg::*;

    localparam int MK = 7;
    localparam int KW = 3;
    localparam int TO = 1024;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          cfg_valid = 1'b0;
    logic [2:0]    cfg_sigma = '0;
    logic [KW-1:0] cfg_kernel_size = '0;
    logic          kb_start;
    logic          kb_done = 1'b0;
    logic          kb_err = 1'b0;
    logic [2:0]    kb_sigma;
    logic [KW-1:0] kb_kernel_size;
    logic          ck_start;
    logic          ck_done = 1'b0;
    logic [7:0]    ck_pixel = '0;
    win_t          ck_matrix;
    logic [KW-1:0] ck_kernel_size;
    logic          ck_clear;
    logic          busy;
    logic [1:0]    err_code;
    logic [15:0]   pix_count;

    int passed = 0;
    int total = 0;

    int  kb_lat = 3;
    bit  kb_err_mode = 1'b0;
    int  ck_lat = 9;
    int  ck_mode = 0;
    logic [KW-1:0] seen_size[$];

    logic [2:0]    m_sig;
    logic [KW-1:0] m_size;
    int            m_cnt;

    always #5 clk = ~clk;

    blur_sequencer_if #(.N(MK)) bus();

    blur_sequencer #(
        .MAX_KERNEL     (MK),
        .KW             (KW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk             (clk),
        .n_rst           (n_rst),
        .cfg_valid       (cfg_valid),
        .cfg_sigma       (cfg_sigma),
        .cfg_kernel_size (cfg_kernel_size),
        .bus             (bus),
        .kb_start        (kb_start),
        .kb_done         (kb_done),
        .kb_err          (kb_err),
        .kb_sigma        (kb_sigma),
        .kb_kernel_size  (kb_kernel_size),
        .ck_start        (ck_start),
        .ck_done         (ck_done),
        .ck_pixel        (ck_pixel),
        .ck_matrix       (ck_matrix),
        .ck_kernel_size  (ck_kernel_size),
        .ck_clear        (ck_clear),
        .busy            (busy),
        .err_code        (err_code),
        .pix_count       (pix_count)
    );

    // Builder stub: answers each kb_start after kb_lat cycles.
    initial forever begin
        @(negedge clk);
        if (kb_start) begin
            repeat (kb_lat - 1) @(negedge clk);
            kb_done = 1'b1;
            kb_err  = kb_err_mode;
            @(negedge clk);
            kb_done = 1'b0;
            kb_err  = 1'b0;
        end
    end

    // Engine stub: mode 0 returns centre^0x5A, 1 returns 77, 2 hangs.
    initial forever begin
        logic [7:0] pv;
        @(negedge clk);
        if (ck_start) begin
            seen_size.push_back(ck_kernel_size);
            pv = (ck_mode == 1) ? 8'd77 : (ck_matrix[3][3] ^ 8'h5A);
            if (ck_mode != 2) begin
                repeat (ck_lat - 1) @(negedge clk);
                ck_done  = 1'b1;
                ck_pixel = pv;
                @(negedge clk);
                ck_done  = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic wait_ready(input int lim, output int n);
        n = 0;
        while (!bus.win_ready && n < lim) begin
            cyc();
            n++;
        end
    endtask

    task automatic wait_pix(input int lim, output int n);
        n = 0;
        while (!bus.pix_valid && n < lim) begin
            cyc();
            n++;
        end
    endtask

    task automatic rand_win(output win_t w);
        for (int r = 0; r < MK; r++)
            for (int c = 0; c < MK; c++)
                w[r][c] = 8'($urandom);
    endtask

    task automatic pulse_cfg(input logic [2:0] sg, input logic [KW-1:0] sz);
        cfg_sigma = sg;
        cfg_kernel_size = sz;
        cfg_valid = 1'b1;
        cyc();
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        repeat (3) cyc();
        total++;
        if ({busy, bus.win_ready, bus.pix_valid, kb_start, ck_start, ck_clear} !== 6'b0)
            $display("FAIL reset_ctl: got %b want 000000",
                {busy, bus.win_ready, bus.pix_valid, kb_start, ck_start, ck_clear});
        else passed++;
        total++;
        if ({err_code, pix_count, bus.pix_data} !== 26'd0 || ck_matrix !== '0)
            $display("FAIL reset_data: err %0d cnt %0d pix %0d want 0",
                err_code, pix_count, bus.pix_data);
        else passed++;
        total++;
        if (kb_sigma !== 3'd1 || kb_kernel_size !== 3'd3 || ck_kernel_size !== 3'd3)
            $display("FAIL reset_cfg: sig %0d size %0d/%0d want 1 3/3",
                kb_sigma, kb_kernel_size, ck_kernel_size);
        else passed++;
        n_rst = 1'b1;
        cyc();
    endtask

    task automatic test_config();
        int n;
        pulse_cfg(3'd1, 3'd3);
        total++;
        if (kb_start !== 1'b1 || ck_clear !== 1'b1 || busy !== 1'b1)
            $display("FAIL cfg_pulse: kb %b clr %b busy %b want 1 1 1",
                kb_start, ck_clear, busy);
        else passed++;
        cyc();
        total++;
        if (kb_start !== 1'b0 || ck_clear !== 1'b0)
            $display("FAIL cfg_one_cycle: kb %b clr %b want 0 0", kb_start, ck_clear);
        else passed++;
        wait_ready(50, n);
        total++;
        if (n >= 50 || err_code !== 2'd0)
            $display("FAIL cfg_ready: wait %0d err %0d want <50 0", n, err_code);
        else passed++;
        m_sig = 3'd1;
        m_size = 3'd3;
        m_cnt = 0;
    endtask

    task automatic test_compute();
        win_t w;
        int n;
        rand_win(w);
        w[3][3] = 8'd200;
        ck_mode = 1;
        ck_lat = 9;
        bus.win_matrix = w;
        bus.win_valid = 1'b1;
        cyc();
        bus.win_valid = 1'b0;
        total++;
        if (ck_start !== 1'b1 || ck_matrix !== w || bus.win_ready !== 1'b0)
            $display("FAIL compute_start: ck_start %b mat_ok %b ready %b want 1 1 0",
                ck_start, ck_matrix === w, bus.win_ready);
        else passed++;
        wait_pix(40, n);
        m_cnt++;
        total++;
        if (n !== 9)
            $display("FAIL compute_latency: got %0d cycles want 9", n);
        else passed++;
        total++;
        if (bus.pix_data !== 8'd77 || pix_count !== 16'(m_cnt))
            $display("FAIL compute_result: pix %0d cnt %0d want 77 %0d",
                bus.pix_data, pix_count, m_cnt);
        else passed++;
    endtask

    task automatic test_stall();
        bit bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (bus.pix_valid !== 1'b1 || bus.pix_data !== 8'd77 || bus.win_ready !== 1'b0)
                bad = 1'b1;
        end
        total++;
        if (bad)
            $display("FAIL stall_hold: pix %0d valid %b ready %b want 77 1 0",
                bus.pix_data, bus.pix_valid, bus.win_ready);
        else passed++;
        bus.pix_ready = 1'b1;
        cyc();
        bus.pix_ready = 1'b0;
        total++;
        if (bus.win_ready !== 1'b1 || bus.pix_valid !== 1'b0)
            $display("FAIL stall_release: ready %b valid %b want 1 0",
                bus.win_ready, bus.pix_valid);
        else passed++;
    endtask

    task automatic test_pending();
        win_t w;
        int n;
        rand_win(w);
        bus.win_matrix = w;
        bus.win_valid = 1'b1;
        cyc();
        bus.win_valid = 1'b0;
        repeat (2) cyc();
        pulse_cfg(3'd2, 3'd5);
        total++;
        if (kb_kernel_size !== 3'd3 || ck_kernel_size !== 3'd3)
            $display("FAIL pend_active: size %0d/%0d want 3", kb_kernel_size, ck_kernel_size);
        else passed++;
        wait_pix(40, n);
        m_cnt++;
        total++;
        if (n >= 40 || pix_count !== 16'(m_cnt) || seen_size[$] !== 3'd3)
            $display("FAIL pend_pixel: wait %0d cnt %0d size %0d want <40 %0d 3",
                n, pix_count, seen_size[$], m_cnt);
        else passed++;
        bus.pix_ready = 1'b1;
        cyc();
        bus.pix_ready = 1'b0;
        m_cnt = 0;
        m_size = 3'd5;
        m_sig = 3'd2;
        total++;
        if (kb_start !== 1'b1 || ck_clear !== 1'b1 || pix_count !== 16'd0 ||
            kb_kernel_size !== m_size || kb_sigma !== m_sig)
            $display("FAIL pend_rebuild: kb %b clr %b cnt %0d size %0d sig %0d want 1 1 0 5 2",
                kb_start, ck_clear, pix_count, kb_kernel_size, kb_sigma);
        else passed++;
        wait_ready(50, n);
    endtask

    task automatic test_cfg_wins();
        int n;
        bus.win_valid = 1'b1;
        pulse_cfg(3'd1, 3'd3);
        bus.win_valid = 1'b0;
        total++;
        if (kb_start !== 1'b1 || ck_start !== 1'b0)
            $display("FAIL cfg_wins: kb %b ck %b want 1 0", kb_start, ck_start);
        else passed++;
        m_sig = 3'd1;
        m_size = 3'd3;
        m_cnt = 0;
        wait_ready(50, n);
    endtask

    task automatic test_random();
        win_t w;
        int n;
        bit pend;
        logic [2:0] psg;
        logic [KW-1:0] psz;
        logic [7:0] exp_pix;
        logic [KW-1:0] exp_size;
        ck_mode = 0;
        seen_size.delete();
        for (int it = 0; it < 16; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                m_sig = 3'($urandom_range(0, 7));
                m_size = 3'(3 + 2 * $urandom_range(0, 2));
                pulse_cfg(m_sig, m_size);
                m_cnt = 0;
                wait_ready(50, n);
            end
            rand_win(w);
            exp_pix = w[3][3] ^ 8'h5A;
            exp_size = m_size;
            ck_lat = $urandom_range(1, 6);
            bus.win_matrix = w;
            bus.win_valid = 1'b1;
            cyc();
            bus.win_valid = 1'b0;
            m_cnt++;
            pend = 1'b0;
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(0, 4)) cyc();
                psg = 3'($urandom_range(0, 7));
                psz = 3'(3 + 2 * $urandom_range(0, 2));
                pulse_cfg(psg, psz);
                pend = 1'b1;
            end
            wait_pix(40, n);
            total++;
            if (n >= 40 || bus.pix_data !== exp_pix || pix_count !== 16'(m_cnt))
                $display("FAIL rand_pix[%0d]: pix %0d cnt %0d want %0d %0d",
                    it, bus.pix_data, pix_count, exp_pix, m_cnt);
            else passed++;
            total++;
            if (seen_size.size() == 0 || seen_size.pop_front() !== exp_size)
                $display("FAIL rand_size[%0d]: engine size wrong, want %0d", it, exp_size);
            else passed++;
            repeat ($urandom_range(0, 3)) cyc();
            bus.pix_ready = 1'b1;
            cyc();
            bus.pix_ready = 1'b0;
            if (pend) begin
                m_sig = psg;
                m_size = psz;
                m_cnt = 0;
            end
            wait_ready(50, n);
            total++;
            if (n >= 50 || kb_kernel_size !== m_size || kb_sigma !== m_sig ||
                pix_count !== 16'(m_cnt))
                $display("FAIL rand_cfg[%0d]: size %0d sig %0d cnt %0d want %0d %0d %0d",
                    it, kb_kernel_size, kb_sigma, pix_count, m_size, m_sig, m_cnt);
            else passed++;
        end
    endtask

    task automatic test_timeout();
        win_t w;
        int n;
        rand_win(w);
        ck_mode = 2;
        bus.win_matrix = w;
        bus.win_valid = 1'b1;
        cyc();
        bus.win_valid = 1'b0;
        n = 0;
        while (err_code !== 2'd2 && n < 1100) begin
            cyc();
            n++;
        end
        total++;
        if (n !== TO)
            $display("FAIL timeout_cycles: got %0d want %0d", n, TO);
        else passed++;
        total++;
        if ({busy, bus.win_ready, bus.pix_valid, kb_start, ck_start} !== 5'b10000)
            $display("FAIL error_outputs: got %b want 10000",
                {busy, bus.win_ready, bus.pix_valid, kb_start, ck_start});
        else passed++;
        ck_mode = 0;
        pulse_cfg(3'd1, 3'd4);
        total++;
        if (err_code !== 2'd3 || kb_start !== 1'b0 || busy !== 1'b1)
            $display("FAIL illegal_size: err %0d kb %b busy %b want 3 0 1",
                err_code, kb_start, busy);
        else passed++;
    endtask

    task automatic test_builder_err();
        int n;
        kb_err_mode = 1'b1;
        pulse_cfg(3'd3, 3'd7);
        total++;
        if (err_code !== 2'd0 || kb_start !== 1'b1)
            $display("FAIL err_clear: err %0d kb %b want 0 1", err_code, kb_start);
        else passed++;
        n = 0;
        while (err_code !== 2'd1 && n < 50) begin
            cyc();
            n++;
        end
        total++;
        if (err_code !== 2'd1)
            $display("FAIL builder_err: err %0d want 1", err_code);
        else passed++;
        kb_err_mode = 1'b0;
        pulse_cfg(3'd1, 3'd3);
        wait_ready(50, n);
        total++;
        if (n >= 50 || err_code !== 2'd0)
            $display("FAIL err_recover: wait %0d err %0d want <50 0", n, err_code);
        else passed++;
    endtask

    task automatic test_reset_midbuild();
        int n;
        bit bad = 1'b0;
        kb_lat = 20;
        pulse_cfg(3'd6, 3'd5);
        repeat (3) cyc();
        n_rst = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || kb_kernel_size !== 3'd3 || kb_sigma !== 3'd1 ||
            pix_count !== 16'd0 || err_code !== 2'd0)
            $display("FAIL async_reset: busy %b size %0d sig %0d cnt %0d err %0d want 0 3 1 0 0",
                busy, kb_kernel_size, kb_sigma, pix_count, err_code);
        else passed++;
        cyc();
        n_rst = 1'b1;
        repeat (25) cyc();
        bus.win_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (bus.win_ready !== 1'b0 || ck_start !== 1'b0 || busy !== 1'b0)
                bad = 1'b1;
        end
        bus.win_valid = 1'b0;
        total++;
        if (bad)
            $display("FAIL refuse_window: ready %b ck %b busy %b want 0 0 0",
                bus.win_ready, ck_start, busy);
        else passed++;
        kb_lat = 3;
        pulse_cfg(3'd1, 3'd3);
        wait_ready(50, n);
        total++;
        if (n >= 50)
            $display("FAIL reload_ready: waited %0d want <50", n);
        else passed++;
    endtask

    initial begin
        bus.win_valid = 1'b0;
        bus.win_matrix = '0;
        bus.pix_ready = 1'b0;
        test_reset();
        test_config();
        test_compute();
        test_stall();
        test_pending();
        test_cfg_wins();
        test_random();
        test_timeout();
        test_builder_err();
        test_reset_midbuild();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
